p20_input_cond: RTL
===================

# p20_input_cond

Input conditioning stage that sits directly upstream of the dino game top. It takes the raw, asynchronous, bouncy jump and halt push-buttons and synchronises and debounces them. It then drives the game's `jump_in` level and `halt_in` level, and adds a one-cycle `jump_press` strobe for consumers that need an edge. This keeps mechanical bounce out of the game's reset-on-jump logic, no-jump counter and RNG entropy.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser flop depth per input; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 250000: stable-level cycles required before an output changes (10 ms at 25 MHz); must be ≥ 1.
- `CTR_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.

Ports:
- `clk`  in  1  pixel/system clock, single clock domain.
- `sys_rst_n`  in  1  reset, asynchronous assert, active-low.
- `jump_btn_in`  in  1  raw jump button, asynchronous, active-high.
- `halt_btn_in`  in  1  raw halt button, asynchronous, active-high.
- `jump_out`  out  1  debounced jump level; connects to game `jump_in`.
- `jump_press`  out  1  one-cycle pulse on each debounced jump rising edge.
- `halt_out`  out  1  halt request; connects to game `halt_in`.
- `halt_press`  out  1  one-cycle pulse on each debounced halt rising edge.

## Operation
- Each input passes through a `SYNC_STAGES`-deep flop chain, then through its own debounce FSM. All outputs are registered.
- Debounce FSM states:
  - `ST_LO`: output 0. If `sync=1`, go to `WAIT_HI` and set `ctr=0`.
  - `WAIT_HI`: output 0.
    - If `sync=0`, go to `ST_LO` (the glitch is rejected).
    - Else, if `ctr==DEBOUNCE_CYCLES-1`, go to `ST_HI`, set output 1 and pulse `rise`.
    - Otherwise `ctr++`.
  - `ST_HI`: output 1. If `sync=0`, go to `WAIT_LO` and set `ctr=0`.
  - `WAIT_LO`: the mirror of `WAIT_HI`. It returns to `ST_HI` if `sync=1`. On `ctr==DEBOUNCE_CYCLES-1` it goes to `ST_LO` and sets output 0. No pulse is generated on a fall.
- Any opposite-level sample during a WAIT state restarts the whole qualification. The counter never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.
- `jump_press` and `halt_press` are the debouncers' `rise` pulses. Each is high for exactly one cycle, in the same cycle that the corresponding level output first reads 1.
- A held button produces exactly one press pulse, with no auto-repeat.
- The two inputs are fully independent. Simultaneous edges on both are processed in parallel, with identical latency.

## Timing
- Reset (async assert, `sys_rst_n=0`):
  - All synchroniser flops are 0, both FSMs are in `ST_LO` with `ctr=0`.
  - `jump_out`, `jump_press`, `halt_out` and `halt_press` are all 0.
- Release from reset is clean: the outputs do not pulse even if a button is already held at release. The held button simply qualifies normally and produces one press after the full latency.
- Latency: count edge 1 as the first rising edge that samples the new raw level. The output changes on edge `SYNC_STAGES + DEBOUNCE_CYCLES + 1`, i.e. 250003 with the defaults. Falling-edge latency is identical.
- Pulses shorter than `DEBOUNCE_CYCLES` synchronised cycles never reach the outputs.
- Reset asserted mid-qualification aborts it immediately. No partial state is retained.

## Configuration
- `P20_HALT_TOGGLE_EN` defined:
  - `halt_out` is a register that toggles on each `halt_press`, so one press pauses and the next press resumes.
  - The register resets to 0.
  - The toggle takes effect in the cycle after `halt_press`.
- `P20_HALT_TOGGLE_EN` undefined:
  - `halt_out` equals the debounced halt level.
  - `halt_press` is still generated.

## Structure
- Shared package `p20_pkg` holds:
  - the debounce state enum (`ST_LO`, `WAIT_HI`, `ST_HI`, `WAIT_LO`, 2-bit);
  - the `P20_DEBOUNCE_DEFAULT` constant (250000).
- Sub-module `p20_debounce` contains one synchroniser, one FSM and one counter, with outputs `level` and `rise`. `p20_input_cond` instantiates it twice and adds the halt toggle logic.

## Test plan
Use `DEBOUNCE_CYCLES=8` and `SYNC_STAGES=2` for all scenarios.
- Reset, then hold `jump_btn_in=1` from edge 1 → `jump_out` rises on edge 11, `jump_press` is high only during that cycle, and no further pulses occur over 100 cycles.
- Jump bounce: 1 for 5 cycles, 0 for 2, then steady 1 → no output during the bounce; `jump_out` rises exactly 11 edges after the final 0→1 sample.
- Release from `ST_HI` with a 3-cycle low glitch → `jump_out` stays 1. A steady release drops it after 11 edges, with no `jump_press`.
- Both buttons pressed on the same edge → `jump_press` and `halt_press` fire in the same cycle (edge 11).
- Halt toggle, with `P20_HALT_TOGGLE_EN` on → two separate halt presses drive `halt_out` 0→1→0. With the macro off, `halt_out` tracks the debounced level.
- `sys_rst_n` pulsed low mid-`WAIT_HI` (`ctr=5`) → outputs go to 0 immediately. After release, the press needs the full 11 edges again.

Source files
------------

// File: rtl/p20_pkg.sv
// Shared types and constants for the p20 input conditioning stage.
package p20_pkg;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } db_state_e;

    // 10 ms at 25 MHz
    localparam int P20_DEBOUNCE_DEFAULT = 250000;

endpackage

// File: rtl/p20_debounce.sv
// One button: synchroniser chain, then a four-state debounce FSM with
// a registered level and a one-cycle rise strobe.
module p20_debounce
    import p20_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = P20_DEBOUNCE_DEFAULT,
    parameter int CTR_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level,
    output logic rise
);

    localparam logic [CTR_W-1:0] LAST = CTR_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_e              state_q, state_d;
    logic [CTR_W-1:0]       ctr_q, ctr_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;

    assign s     = sync_q[SYNC_STAGES-1];
    assign level = level_q;
    assign rise  = rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ST_LO;
            ctr_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
            state_q <= state_d;
            ctr_q   <= ctr_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    // Any opposite-level sample in a WAIT state drops back to the stable state.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        level_d = level_q;
        rise_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    ctr_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = ST_LO;
                end else if (ctr_q == LAST) begin
                    state_d = ST_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            ST_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    ctr_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = ST_HI;
                end else if (ctr_q == LAST) begin
                    state_d = ST_LO;
                    level_d = 1'b0;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            default: state_d = ST_LO;
        endcase
    end

endmodule

// File: rtl/p20_input_cond.sv
// Debounced jump/halt conditioning for the dino game top.
// Define P20_HALT_TOGGLE_EN to make halt_out a press-to-toggle pause latch.
module p20_input_cond
    import p20_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = P20_DEBOUNCE_DEFAULT,
    parameter int CTR_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic sys_rst_n,
    input  logic jump_btn_in,
    input  logic halt_btn_in,
    output logic jump_out,
    output logic jump_press,
    output logic halt_out,
    output logic halt_press
);

    logic halt_lvl;

    p20_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CTR_W          (CTR_W)
    ) u_jump (
        .clk  (clk),
        .rst_n(sys_rst_n),
        .btn_i(jump_btn_in),
        .level(jump_out),
        .rise (jump_press)
    );

    p20_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CTR_W          (CTR_W)
    ) u_halt (
        .clk  (clk),
        .rst_n(sys_rst_n),
        .btn_i(halt_btn_in),
        .level(halt_lvl),
        .rise (halt_press)
    );

`ifdef P20_HALT_TOGGLE_EN
    logic halt_tog_q;

    // Flips the cycle after each press strobe: press once to pause, again to resume.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) halt_tog_q <= 1'b0;
        else            halt_tog_q <= halt_tog_q ^ halt_press;
    end

    assign halt_out = halt_tog_q;
`else
    assign halt_out = halt_lvl;
`endif

endmodule
